// File: rtl/multi_slot_io_mux_pkg.sv
// Shared constants for the multi-slot pad multiplexer: FSM states, register map, STATUS layout.
package multi_slot_io_mux_pkg;

  localparam int unsigned SLOT_W  = 4;
  localparam int unsigned STATE_W = 2;

  // Owner FSM states (encoding is visible in STATUS[9:8])
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd1;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd2;

  // Register byte offsets inside the 16-byte window
  localparam logic [3:0] OFS_SEL      = 4'h0;
  localparam logic [3:0] OFS_STATUS   = 4'h4;
  localparam logic [3:0] OFS_FORCE_LO = 4'h8;
  localparam logic [3:0] OFS_FORCE_HI = 4'hC;

  // SEL / STATUS bit positions
  localparam int unsigned SEL_EN_BIT    = 31;
  localparam int unsigned ST_ACTIVE_LSB = 0;
  localparam int unsigned ST_STATE_LSB  = 8;
  localparam int unsigned ST_BUSY_BIT   = 16;
  localparam int unsigned ST_ERR_BIT    = 24;

  // Merge a 32-bit write into an old value honouring byte enables
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_slot_io_mux_regs.sv
// Wishbone register block: decode, single-cycle ack, SEL/FORCE registers and sticky error.
module multi_slot_io_mux_regs
  import multi_slot_io_mux_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned IO_WIDTH  = 38,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic [31:0]         wbs_dat_o,
  output logic                wbs_ack_o,
  input  logic [STATE_W-1:0]  state,
  input  logic [SLOT_W-1:0]   active,
  output logic                sel_wr_c,
  output logic [SLOT_W-1:0]   sel_slot_c,
  output logic                sel_en_c,
  output logic [IO_WIDTH-1:0] force_oeb
);

  localparam int unsigned HI_W = IO_WIDTH - 32;

  logic [SLOT_W-1:0] sel_slot_q;
  logic              sel_en_q;
  logic              err_q;
  logic [31:0]       force_lo_q;
  logic [HI_W-1:0]   force_hi_q;

  logic        req_c;
  logic        wr_c;
  logic        rd_c;
  logic        sel_hit_c;
  logic        slot_ok_c;
  logic        err_clr_c;
  logic [31:0] status_c;
  logic [31:0] rdata_c;

  assign force_oeb = {force_hi_q, force_lo_q};

  // Request decode, SEL merge/validation and read mux
  always_comb begin
    req_c      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
    wr_c       = req_c & wbs_we_i;
    rd_c       = req_c & ~wbs_we_i;
    sel_slot_c = wbs_sel_i[0] ? wbs_dat_i[SLOT_W-1:0] : sel_slot_q;
    sel_en_c   = wbs_sel_i[3] ? wbs_dat_i[SEL_EN_BIT] : sel_en_q;
    slot_ok_c  = ({1'b0, sel_slot_c} < 5'(NUM_SLOTS));
    sel_hit_c  = wr_c & (wbs_adr_i[3:0] == OFS_SEL);
    sel_wr_c   = sel_hit_c & slot_ok_c;
    err_clr_c  = wr_c & (wbs_adr_i[3:0] == OFS_STATUS) & wbs_sel_i[3] & wbs_dat_i[ST_ERR_BIT];

    status_c = '0;
    status_c[ST_ACTIVE_LSB +: SLOT_W] = active;
    status_c[ST_STATE_LSB +: STATE_W] = state;
    status_c[ST_BUSY_BIT]             = (state == ST_DRAIN);
    status_c[ST_ERR_BIT]              = err_q;

    case (wbs_adr_i[3:0])
      OFS_SEL:      rdata_c = {sel_en_q, 27'b0, sel_slot_q};
      OFS_STATUS:   rdata_c = status_c;
      OFS_FORCE_LO: rdata_c = force_lo_q;
      OFS_FORCE_HI: rdata_c = 32'(force_hi_q);
      default:      rdata_c = '0;
    endcase
  end

  // Ack/read-data registers and register writes at the ack-raising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      sel_slot_q <= '0;
      sel_en_q   <= 1'b0;
      err_q      <= 1'b0;
      force_lo_q <= '0;
      force_hi_q <= '0;
    end else begin
      wbs_ack_o <= req_c;
      wbs_dat_o <= rd_c ? rdata_c : '0;
      if (sel_wr_c) begin
        sel_slot_q <= sel_slot_c;
        sel_en_q   <= sel_en_c;
      end
      if (sel_hit_c && !slot_ok_c) begin
        err_q <= 1'b1;
      end else if (err_clr_c) begin
        err_q <= 1'b0;
      end
      if (wr_c && (wbs_adr_i[3:0] == OFS_FORCE_LO)) begin
        force_lo_q <= be_merge(force_lo_q, wbs_dat_i, wbs_sel_i);
      end
      if (wr_c && (wbs_adr_i[3:0] == OFS_FORCE_HI)) begin
        force_hi_q <= HI_W'(be_merge(32'(force_hi_q), wbs_dat_i, wbs_sel_i));
      end
    end
  end

endmodule

// File: rtl/multi_slot_io_mux.sv
// Pad multiplexer: owner FSM with guarded drain between slot owners, pad mux and slot resets.
module multi_slot_io_mux
  import multi_slot_io_mux_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 4,
  parameter int unsigned IO_WIDTH     = 38,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int unsigned DEFAULT_SLOT = 0,
  parameter bit          DEFAULT_EN   = 1'b1
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_we_i,
  input  logic [3:0]                    wbs_sel_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  output logic [31:0]                   wbs_dat_o,
  output logic                          wbs_ack_o,
  input  logic [IO_WIDTH-1:0]           io_in,
  output logic [IO_WIDTH-1:0]           io_out,
  output logic [IO_WIDTH-1:0]           io_oeb,
  output logic [NUM_SLOTS*IO_WIDTH-1:0] slot_io_in,
  input  logic [NUM_SLOTS*IO_WIDTH-1:0] slot_io_out,
  input  logic [NUM_SLOTS*IO_WIDTH-1:0] slot_io_oeb,
  output logic [NUM_SLOTS-1:0]          slot_rst_n
);

  localparam int unsigned       CNT_W      = $clog2(GUARD_CYCLES);
  localparam logic [CNT_W-1:0]  GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SLOT_W-1:0]  pend_slot_q, pend_slot_d;
  logic               pend_en_q, pend_en_d;
  logic [SLOT_W-1:0]  active_q, active_d;
  logic               boot_q, boot_d;

  logic                sel_wr_c;
  logic [SLOT_W-1:0]   sel_slot_c;
  logic                sel_en_c;
  logic [IO_WIDTH-1:0] force_oeb;
  logic [IO_WIDTH-1:0] act_out_c;
  logic [IO_WIDTH-1:0] act_oeb_c;
  logic [NUM_SLOTS-1:0] rst_onehot_c;

  multi_slot_io_mux_regs #(
    .NUM_SLOTS (NUM_SLOTS),
    .IO_WIDTH  (IO_WIDTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_n),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_ack_o  (wbs_ack_o),
    .state      (state_q),
    .active     (active_q),
    .sel_wr_c   (sel_wr_c),
    .sel_slot_c (sel_slot_c),
    .sel_en_c   (sel_en_c),
    .force_oeb  (force_oeb)
  );

  // Owner FSM state registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_slot_q <= '0;
      pend_en_q   <= 1'b0;
      active_q    <= '0;
      boot_q      <= DEFAULT_EN;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_slot_q <= pend_slot_d;
      pend_en_q   <= pend_en_d;
      active_q    <= active_d;
      boot_q      <= boot_d;
    end
  end

  // Next state: SEL writes start/restart a drain, drain expiry hands the pads over
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_slot_d = pend_slot_q;
    pend_en_d   = pend_en_q;
    active_d    = active_q;
    boot_d      = boot_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_wr_c && sel_en_c) begin
          pend_slot_d = sel_slot_c;
          pend_en_d   = 1'b1;
          cnt_d       = GUARD_LOAD;
          state_d     = ST_DRAIN;
          boot_d      = 1'b0;
        end else if (boot_q) begin
          pend_slot_d = SLOT_W'(DEFAULT_SLOT);
          pend_en_d   = 1'b1;
          cnt_d       = GUARD_LOAD;
          state_d     = ST_DRAIN;
          boot_d      = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (sel_wr_c) begin
          pend_slot_d = sel_slot_c;
          pend_en_d   = sel_en_c;
          cnt_d       = GUARD_LOAD;
        end else if (cnt_q == '0) begin
          if (pend_en_q) begin
            state_d  = ST_RUN;
            active_d = pend_slot_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (sel_wr_c && (!sel_en_c || (sel_slot_c != active_q))) begin
          pend_slot_d = sel_slot_c;
          pend_en_d   = sel_en_c;
          cnt_d       = GUARD_LOAD;
          state_d     = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad mux from the active slot; everything tri-stated unless in RUN
  always_comb begin
    act_out_c    = '0;
    act_oeb_c    = '1;
    rst_onehot_c = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (active_q == SLOT_W'(i)) begin
        act_out_c       = slot_io_out[i*IO_WIDTH +: IO_WIDTH];
        act_oeb_c       = slot_io_oeb[i*IO_WIDTH +: IO_WIDTH];
        rst_onehot_c[i] = 1'b1;
      end
    end
    io_out = '0;
    io_oeb = '1;
    if (state_q == ST_RUN) begin
      io_out = act_out_c;
      io_oeb = act_oeb_c | force_oeb;
    end
    slot_io_in = {NUM_SLOTS{io_in}};
  end

  // Slot resets: release one cycle into RUN, assert on the edge that leaves RUN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      slot_rst_n <= '0;
    end else begin
      slot_rst_n <= ((state_q == ST_RUN) && (state_d == ST_RUN)) ? rst_onehot_c : '0;
    end
  end

endmodule
